// File: rtl/decode_sequencer_if.sv
// Fetch-side and decoder-side handshake bundle for the decode sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding pipeline's view.
interface decode_sequencer_if #(
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = 64
);
    logic                         in_valid;
    logic [BUS_DATA_WIDTH-1:0]    in_data;
    logic [ADDR_WIDTH-1:0]        in_pc;
    logic                         in_ready;
    logic                         out_valid;
    logic [INSTRUCTION_WIDTH-1:0] out_inst;
    logic [ADDR_WIDTH-1:0]        out_pc;
    logic                         out_ready;
    logic                         flush;
    logic                         halt;
    logic [31:0]                  inst_count;

    modport slave (
        input  in_valid, in_data, in_pc, out_ready, flush,
        output in_ready, out_valid, out_inst, out_pc, halt, inst_count
    );

    modport master (
        output in_valid, in_data, in_pc, out_ready, flush,
        input  in_ready, out_valid, out_inst, out_pc, halt, inst_count
    );
endinterface

// File: rtl/decode_sequencer.sv
// Splits each two-slot fetch word into single instructions for the decoder.
// The sequencer stops at the first all-zero instruction and stays halted until it is flushed.
module decode_sequencer #(
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = 64
) (
    input logic                clk,
    input logic                reset,
    decode_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, HALT} state_t;

    state_t                       state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0]    word_q, word_d;
    logic [ADDR_WIDTH-4:0]        base_q, base_d;
    logic [31:0]                  instCount_q;
    logic [INSTRUCTION_WIDTH-1:0] curInst;
    logic                         outValid, outXfer, inReady, inXfer, loadWord;
    logic                         unusedPcBits;

    // The byte offset within a slot carries no information; only bit 2 selects the slot.
    assign unusedPcBits = ^bus.in_pc[1:0];

    always_comb begin
        curInst = '0;
        case (state_q)
            LOW:     curInst = word_q[INSTRUCTION_WIDTH-1:0];
            HIGH:    curInst = word_q[BUS_DATA_WIDTH-1:INSTRUCTION_WIDTH];
            default: curInst = '0;
        endcase
    end

    assign outValid = ((state_q == LOW) || (state_q == HIGH)) && (curInst != '0);
    assign outXfer  = outValid && bus.out_ready;
    assign inReady  = (state_q == IDLE) || ((state_q == HIGH) && outXfer);
    assign inXfer   = bus.in_valid && inReady;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        base_d   = base_q;
        loadWord = 1'b0;
        case (state_q)
            IDLE: loadWord = inXfer;
            LOW: begin
                if (curInst == '0)
                    state_d = HALT;
                else if (outXfer)
                    state_d = HIGH;
            end
            HIGH: begin
                if (curInst == '0)
                    state_d = HALT;
                else if (outXfer) begin
                    state_d  = IDLE;
                    loadWord = inXfer;
                end
            end
            default: state_d = HALT;
        endcase
        if (loadWord) begin
            word_d  = bus.in_data;
            base_d  = bus.in_pc[ADDR_WIDTH-1:3];
            state_d = bus.in_pc[2] ? HIGH : LOW;
        end
        // Flush wins over everything, including a word arriving in the same cycle.
        if (bus.flush) begin
            state_d = IDLE;
            word_d  = '0;
            base_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            base_q      <= '0;
            instCount_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            base_q  <= base_d;
            if (outXfer && !bus.flush)
                instCount_q <= instCount_q + 32'd1;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_inst   = curInst;
    assign bus.out_pc     = {base_q, (state_q == HIGH), 2'b00};
    assign bus.halt       = (state_q == HALT);
    assign bus.inst_count = instCount_q;
endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: expected instructions are queued when a word is
// offered and checked off by a monitor as the decoder side accepts them.
module tb_decode_sequencer;
    localparam int BW = 64;
    localparam int IW = 32;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    decode_sequencer_if #(.BUS_DATA_WIDTH(BW), .INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) bus();

    decode_sequencer #(.BUS_DATA_WIDTH(BW), .INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t expQ[$];
    int   xferCycles[$];
    int   cycleCnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    // Every accepted decoder-side transfer must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && bus.flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xferCycles.push_back(cycleCnt);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output_pending", 64'(expQ.size()), 64'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_inst", 64'(bus.out_inst), 64'(e.inst));
                checkOutput("out_pc", bus.out_pc, e.pc);
            end
        end
    end

    task automatic applyStimulus(input logic [BW-1:0] data, input logic [AW-1:0] pc);
        logic [AW-1:0] base;
        logic [IW-1:0] inst;
        bit            accepted;
        int            n;
        base = {pc[AW-1:3], 3'b000};
        for (int s = int'(pc[2]); s < 2; s++) begin
            inst = (s == 0) ? data[IW-1:0] : data[BW-1:IW];
            if (inst == '0) break;
            expQ.push_back('{inst: inst, pc: base + AW'(4 * s)});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_pc    = pc;
        accepted     = 1'b0;
        n            = 0;
        while (!accepted && n < 20) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checkOutput("in_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_inst", 64'(bus.out_inst), 64'd0);
        checkOutput("rst_out_pc", bus.out_pc, 64'd0);
        checkOutput("rst_halt", 64'(bus.halt), 64'd0);
        checkOutput("rst_inst_count", 64'(bus.inst_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Aligned word, both slots, with one-cycle latency
        bus.out_ready = 1'b1;
        applyStimulus(64'h00500093_00100093, 64'h1000);
        checkOutput("latency_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("latency_out_inst", 64'(bus.out_inst), 64'h00100093);
        checkOutput("latency_out_pc", bus.out_pc, 64'h1000);
        waitDrain();
        checkOutput("pair_idle_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("pair_idle_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("pair_inst_count", 64'(bus.inst_count), 64'd2);

        // Entry at the high slot skips the low instruction
        applyStimulus(64'h00500093_00100093, 64'h1004);
        checkOutput("skip_out_pc", bus.out_pc, 64'h1004);
        waitDrain();
        checkOutput("skip_inst_count", 64'(bus.inst_count), 64'd3);

        // Zero instruction halts the sequencer until flush
        applyStimulus(64'h00000000_00100093, 64'h2000);
        waitDrain();
        checkOutput("zero_hidden_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("halt_asserted", 64'(bus.halt), 64'd1);
        checkOutput("halt_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("halt_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("halt_inst_count", 64'(bus.inst_count), 64'd4);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flush_halt", 64'(bus.halt), 64'd0);
        checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("flush_inst_count", 64'(bus.inst_count), 64'd4);

        // Downstream stall holds the low-slot output steady
        bus.out_ready = 1'b0;
        applyStimulus(64'h11111111_22222223, 64'h3000);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_out_inst", 64'(bus.out_inst), 64'h22222223);
            checkOutput("stall_out_pc", bus.out_pc, 64'h3000);
            checkOutput("stall_inst_count", 64'(bus.inst_count), 64'd4);
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("stall_drain_count", 64'(bus.inst_count), 64'd6);

        // Back-to-back words stream one instruction per cycle
        xferCycles.delete();
        for (int k = 0; k < 4; k++)
            applyStimulus({32'h00A00013 + 32'(2 * k + 1), 32'h00A00013 + 32'(2 * k)}, 64'h4000 + 64'(8 * k));
        waitDrain();
        checkOutput("stream_xfers", 64'(xferCycles.size()), 64'd8);
        if (xferCycles.size() == 8)
            checkOutput("stream_span", 64'(xferCycles[7] - xferCycles[0]), 64'd7);
        checkOutput("stream_inst_count", 64'(bus.inst_count), 64'd14);

        // Counter wraps from all-ones to zero
        @(negedge clk);
        force dut.instCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.instCount_q;
        @(posedge clk);
        #1;
        checkOutput("wrap_preload", 64'(bus.inst_count), 64'hFFFF_FFFF);
        applyStimulus(64'h00700093_00000000, 64'h5004);
        waitDrain();
        checkOutput("wrap_inst_count", 64'(bus.inst_count), 64'd0);

        // Asynchronous reset while holding the high slot
        bus.out_ready = 1'b0;
        applyStimulus(64'h00900093_00000000, 64'h6004);
        checkOutput("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_rst_halt", 64'(bus.halt), 64'd0);
        checkOutput("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("async_rst_out_pc", bus.out_pc, 64'd0);
        checkOutput("async_rst_inst_count", 64'(bus.inst_count), 64'd0);
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
